// File: rtl/uart_rx_core.sv
// Purpose : 8N1 UART receiver with 16x oversampling, selectable bit rate and a one-byte holding register.
// Latency : RxData/RxStatus update one RSClk after the stop-bit centre tick (~152*DIV + 3 cycles after start edge).
// Backpressure: none on the line; an unfetched byte is overwritten and flagged as overrun (RxStatus 11).
// Ports   : RSClk clock, Reset_n async active-low reset, RxBitRate rate select, xipRXD async serial in,
//           RxFetch consumer-taken pulse, RxData last byte, RxStatus 00/01/10/11, RxBusy frame in progress.
module uart_rx_core #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       RSClk,
    input  logic       Reset_n,
    input  logic [3:0] RxBitRate,
    input  logic       xipRXD,
    input  logic       RxFetch,
    output logic [7:0] RxData,
    output logic [1:0] RxStatus,
    output logic       RxBusy
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [8:0] DIV_9600   = 9'd326;
    localparam logic [1:0] FLUSH_LAST = 2'(SYNC_STAGES);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [1:0]             flush_q, flush_d;
    logic                   line_prev_q, line_prev_d;
    logic [8:0]             div_q, div_d;
    logic [8:0]             prescale_q, prescale_d;
    logic [3:0]             tick_cnt_q, tick_cnt_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             data_q, data_d;
    logic [1:0]             status_q, status_d;
    logic                   busy_q, busy_d;

    logic       rxd_s;
    logic       fall;
    logic       tick;
    logic       load;
    logic [8:0] rate_div;

    always_comb begin
        case (RxBitRate)
            4'd1:    rate_div = 9'd163;
            4'd2:    rate_div = 9'd81;
            4'd3:    rate_div = 9'd54;
            4'd4:    rate_div = 9'd27;
            default: rate_div = DIV_9600;
        endcase
    end

    always_comb begin
        rxd_s = sync_q[SYNC_STAGES-1];
        fall  = line_prev_q & ~rxd_s;
        tick  = (prescale_q == (div_q - 9'd1));

        sync_d  = {sync_q[SYNC_STAGES-2:0], xipRXD};
        flush_d = (flush_q == FLUSH_LAST) ? flush_q : flush_q + 2'd1;
        // The synchroniser resets to all-ones, so its output is not the real line
        // until it has been flushed. Until then the previous-line value is forced
        // low, so a line held low through reset release never looks like a start edge.
        line_prev_d = (flush_q == FLUSH_LAST) ? rxd_s : 1'b0;

        state_d    = state_q;
        div_d      = div_q;
        prescale_d = tick ? 9'd0 : prescale_q + 9'd1;
        tick_cnt_d = tick ? tick_cnt_q + 4'd1 : tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        status_d   = status_q;
        load       = 1'b0;

        case (state_q)
            IDLE: begin
                // Rate is only sampled between frames; counters are held clear so
                // the first tick lands DIV cycles after the start edge.
                div_d      = rate_div;
                prescale_d = 9'd0;
                tick_cnt_d = 4'd0;
                bit_cnt_d  = 3'd0;
                if (fall) begin
                    state_d = START;
                end
            end
            START: begin
                if (tick && tick_cnt_q == 4'd7) begin
                    if (rxd_s) begin
                        state_d = IDLE;
                    end else begin
                        tick_cnt_d = 4'd0;
                        state_d    = DATA;
                    end
                end
            end
            DATA: begin
                if (tick && tick_cnt_q == 4'd15) begin
                    shift_d   = {rxd_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                // Returning to IDLE at the stop centre lets the next start edge be
                // caught in the second half of the stop bit.
                if (tick && tick_cnt_q == 4'd15) begin
                    load    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            data_d = shift_q;
            if (!rxd_s) begin
                status_d = 2'b10;
            end else if (status_q != 2'b00 && !RxFetch) begin
                status_d = 2'b11;
            end else begin
                status_d = 2'b01;
            end
        end else if (RxFetch && status_q != 2'b00) begin
            status_d = 2'b00;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge RSClk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            sync_q      <= '1;
            flush_q     <= 2'd0;
            line_prev_q <= 1'b0;
            div_q       <= DIV_9600;
            prescale_q  <= 9'd0;
            tick_cnt_q  <= 4'd0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            data_q      <= 8'h00;
            status_q    <= 2'b00;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            flush_q     <= flush_d;
            line_prev_q <= line_prev_d;
            div_q       <= div_d;
            prescale_q  <= prescale_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            status_q    <= status_d;
            busy_q      <= busy_d;
        end
    end

    assign RxData   = data_q;
    assign RxStatus = status_q;
    assign RxBusy   = busy_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Purpose : directed bench for uart_rx_core covering reception, false start, overrun, break, reset and rate change.
// Latency : expectations are derived from 152 oversample ticks per frame plus synchroniser delay.
// Backpressure: RxFetch pulses are driven by the bench to clear or race the holding register.
module tb_uart_rx_core;

    logic       RSClk     = 1'b0;
    logic       Reset_n   = 1'b0;
    logic [3:0] RxBitRate = 4'd4;
    logic       xipRXD    = 1'b1;
    logic       RxFetch   = 1'b0;
    logic [7:0] RxData;
    logic [1:0] RxStatus;
    logic       RxBusy;

    int n_tests = 0;
    int n_fail  = 0;

    uart_rx_core #(.SYNC_STAGES(2)) dut (
        .RSClk    (RSClk),
        .Reset_n  (Reset_n),
        .RxBitRate(RxBitRate),
        .xipRXD   (xipRXD),
        .RxFetch  (RxFetch),
        .RxData   (RxData),
        .RxStatus (RxStatus),
        .RxBusy   (RxBusy)
    );

    always #10 RSClk = ~RSClk;

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge RSClk);
    endtask

    task automatic fetch();
        @(negedge RSClk);
        RxFetch = 1'b1;
        @(negedge RSClk);
        RxFetch = 1'b0;
        wait_cyc(2);
    endtask

    // Start bit, 8 data bits LSB first, then the stop level held for 10 ticks
    // (past the stop-bit centre) before the line returns to idle.
    task automatic send_byte(input logic [7:0] b, input logic stop, input int div);
        int bit_t;
        bit_t = 16 * div;
        @(negedge RSClk);
        xipRXD = 1'b0;
        wait_cyc(bit_t);
        for (int i = 0; i < 8; i++) begin
            xipRXD = b[i];
            wait_cyc(bit_t);
        end
        xipRXD = stop;
        wait_cyc(10 * div);
        xipRXD = 1'b1;
        wait_cyc(20);
    endtask

    task automatic test_reset();
        wait_cyc(5);
        n_tests++;
        if (RxData !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected %h", RxData, 8'h00); end
        n_tests++;
        if (RxStatus !== 2'b00) begin n_fail++; $display("FAIL reset_status: got %b expected %b", RxStatus, 2'b00); end
        n_tests++;
        if (RxBusy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected %b", RxBusy, 1'b0); end
        Reset_n = 1'b1;
        wait_cyc(20);
    endtask

    task automatic test_basic();
        int   lat;
        logic mid_busy;
        lat      = -1;
        mid_busy = 1'b0;
        RxBitRate = 4'd4;
        fork
            send_byte(8'h55, 1'b1, 27);
            begin
                @(negedge RSClk);
                for (int c = 1; c <= 6000; c++) begin
                    @(negedge RSClk);
                    if (c == 2000) mid_busy = RxBusy;
                    if (RxStatus !== 2'b00 && lat < 0) lat = c;
                end
            end
        join
        n_tests++;
        if (mid_busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_mid: got %b expected %b", mid_busy, 1'b1); end
        n_tests++;
        if (lat < 4074 || lat > 4134) begin n_fail++; $display("FAIL basic_latency: got %0d cycles expected 4074..4134", lat); end
        n_tests++;
        if (RxData !== 8'h55) begin n_fail++; $display("FAIL basic_data: got %h expected %h", RxData, 8'h55); end
        n_tests++;
        if (RxStatus !== 2'b01) begin n_fail++; $display("FAIL basic_status: got %b expected %b", RxStatus, 2'b01); end
        n_tests++;
        if (RxBusy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end: got %b expected %b", RxBusy, 1'b0); end
    endtask

    task automatic test_false_start();
        fetch();
        n_tests++;
        if (RxStatus !== 2'b00) begin n_fail++; $display("FAIL fetch_clear_status: got %b expected %b", RxStatus, 2'b00); end
        n_tests++;
        if (RxData !== 8'h55) begin n_fail++; $display("FAIL fetch_hold_data: got %h expected %h", RxData, 8'h55); end
        @(negedge RSClk);
        xipRXD = 1'b0;
        wait_cyc(50);
        n_tests++;
        if (RxBusy !== 1'b1) begin n_fail++; $display("FAIL false_start_busy: got %b expected %b", RxBusy, 1'b1); end
        wait_cyc(50);
        xipRXD = 1'b1;
        wait_cyc(300);
        n_tests++;
        if (RxBusy !== 1'b0) begin n_fail++; $display("FAIL false_start_idle: got %b expected %b", RxBusy, 1'b0); end
        n_tests++;
        if (RxStatus !== 2'b00) begin n_fail++; $display("FAIL false_start_status: got %b expected %b", RxStatus, 2'b00); end
        n_tests++;
        if (RxData !== 8'h55) begin n_fail++; $display("FAIL false_start_data: got %h expected %h", RxData, 8'h55); end
    endtask

    task automatic test_overrun();
        send_byte(8'h11, 1'b1, 27);
        n_tests++;
        if (RxData !== 8'h11 || RxStatus !== 2'b01) begin
            n_fail++; $display("FAIL ovr_first: got %h/%b expected %h/%b", RxData, RxStatus, 8'h11, 2'b01);
        end
        send_byte(8'h22, 1'b1, 27);
        n_tests++;
        if (RxData !== 8'h22 || RxStatus !== 2'b11) begin
            n_fail++; $display("FAIL ovr_second: got %h/%b expected %h/%b", RxData, RxStatus, 8'h22, 2'b11);
        end
        // Load happens in the cycle ending at the 4107th rising edge after the start edge.
        fork
            send_byte(8'h33, 1'b1, 27);
            begin
                @(negedge RSClk);
                wait_cyc(2 + 152 * 27);
                RxFetch = 1'b1;
                @(negedge RSClk);
                RxFetch = 1'b0;
            end
        join
        n_tests++;
        if (RxData !== 8'h33 || RxStatus !== 2'b01) begin
            n_fail++; $display("FAIL ovr_fetch_on_load: got %h/%b expected %h/%b", RxData, RxStatus, 8'h33, 2'b01);
        end
    endtask

    task automatic test_reset_midframe();
        int busy_hi;
        busy_hi = 0;
        @(negedge RSClk);
        xipRXD = 1'b0;           // start + bits 0..3 of F0 are all low
        wait_cyc(1900);          // inside data bit 3
        n_tests++;
        if (RxBusy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy_before: got %b expected %b", RxBusy, 1'b1); end
        Reset_n = 1'b0;
        wait_cyc(3);
        n_tests++;
        if (RxData !== 8'h00) begin n_fail++; $display("FAIL rst_mid_data: got %h expected %h", RxData, 8'h00); end
        n_tests++;
        if (RxStatus !== 2'b00) begin n_fail++; $display("FAIL rst_mid_status: got %b expected %b", RxStatus, 2'b00); end
        n_tests++;
        if (RxBusy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected %b", RxBusy, 1'b0); end
        Reset_n = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge RSClk);
            if (RxBusy === 1'b1) busy_hi++;
        end
        n_tests++;
        if (busy_hi != 0) begin n_fail++; $display("FAIL rst_low_line_no_start: got %0d busy cycles expected 0", busy_hi); end
        xipRXD = 1'b1;
        wait_cyc(50);
        send_byte(8'h0F, 1'b1, 27);
        n_tests++;
        if (RxData !== 8'h0F || RxStatus !== 2'b01) begin
            n_fail++; $display("FAIL rst_after_frame: got %h/%b expected %h/%b", RxData, RxStatus, 8'h0F, 2'b01);
        end
    endtask

    task automatic test_break();
        int busy_hi;
        busy_hi = 0;
        fetch();
        fetch();                 // status already 00: must be ignored
        n_tests++;
        if (RxData !== 8'h0F || RxStatus !== 2'b00) begin
            n_fail++; $display("FAIL fetch_when_empty: got %h/%b expected %h/%b", RxData, RxStatus, 8'h0F, 2'b00);
        end
        @(negedge RSClk);
        xipRXD = 1'b0;
        wait_cyc(9 * 432 + 10 * 27);
        n_tests++;
        if (RxData !== 8'h00 || RxStatus !== 2'b10) begin
            n_fail++; $display("FAIL break_result: got %h/%b expected %h/%b", RxData, RxStatus, 8'h00, 2'b10);
        end
        for (int c = 0; c < 500; c++) begin
            @(negedge RSClk);
            if (RxBusy === 1'b1) busy_hi++;
        end
        n_tests++;
        if (busy_hi != 0) begin n_fail++; $display("FAIL break_wait_idle: got %0d busy cycles expected 0", busy_hi); end
        xipRXD = 1'b1;
        wait_cyc(50);
        fetch();
        n_tests++;
        if (RxStatus !== 2'b00) begin n_fail++; $display("FAIL break_fetch: got %b expected %b", RxStatus, 2'b00); end
    endtask

    task automatic test_rate_change();
        RxBitRate = 4'd4;
        fork
            send_byte(8'hC6, 1'b1, 27);
            begin
                wait_cyc(2000);
                RxBitRate = 4'd0;
            end
        join
        n_tests++;
        if (RxData !== 8'hC6 || RxStatus !== 2'b01) begin
            n_fail++; $display("FAIL rate_cur_frame: got %h/%b expected %h/%b", RxData, RxStatus, 8'hC6, 2'b01);
        end
        fetch();
        send_byte(8'hA3, 1'b0, 326);
        n_tests++;
        if (RxData !== 8'hA3) begin n_fail++; $display("FAIL slow_data: got %h expected %h", RxData, 8'hA3); end
        n_tests++;
        if (RxStatus !== 2'b10) begin n_fail++; $display("FAIL slow_framing: got %b expected %b", RxStatus, 2'b10); end
        fetch();
        n_tests++;
        if (RxData !== 8'hA3 || RxStatus !== 2'b00) begin
            n_fail++; $display("FAIL slow_fetch: got %h/%b expected %h/%b", RxData, RxStatus, 8'hA3, 2'b00);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_false_start();
        test_overrun();
        test_reset_midframe();
        test_break();
        test_rate_change();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
